// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_pkg
//  Description : Shared types, default widths and packed-bus index helper
//                for the multi-port register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_NUM_RD     = 2;

  // Start-up sequencing: CLEAR zeroes the array, READY serves traffic.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

  // LSB position of lane 'port' inside a flattened bus of 'width'-bit lanes.
  function automatic int rf_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp_if
//  Description : Access bus of the multi-port register file: write port,
//                packed read ports, scoreboard set port and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_RD     = RF_NUM_RD
) ();

  logic                             init_done;
  logic                             wen;
  logic [ADDR_WIDTH-1:0]            waddr;
  logic [DATA_WIDTH-1:0]            wdata;
  logic [NUM_RD*ADDR_WIDTH-1:0]     raddr;
  logic [NUM_RD*DATA_WIDTH-1:0]     rdata;
  logic                             busy_set;
  logic [ADDR_WIDTH-1:0]            busy_addr;
  logic [NUM_RD-1:0]                rbusy;

  // Pipeline side: drives requests, observes data and status.
  modport master (
    input  init_done, rdata, rbusy,
    output wen, waddr, wdata, raddr, busy_set, busy_addr
  );

  // Register file side.
  modport slave (
    output init_done, rdata, rbusy,
    input  wen, waddr, wdata, raddr, busy_set, busy_addr
  );

endinterface
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_scoreboard
//  Description : Pending-write busy bits. A set marks a new producer, an
//                accepted write retires it; set beats clear on the same index.
//                Provides the per-read-port busy lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_RD     = RF_NUM_RD,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic                         clr_i,
  input  logic [ADDR_WIDTH-1:0]        clr_addr_i,
  input  logic                         set_i,
  input  logic [ADDR_WIDTH-1:0]        set_addr_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr_i,
  input  logic [NUM_RD-1:0]            hit_i,
  output logic [NUM_RD-1:0]            rbusy_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             set_ok;

  // Entry 0 can never gain a producer when it is hardwired to zero.
  assign set_ok = en_i && set_i && !((ZERO_REG != 0) && (set_addr_i == '0));

  // Next busy vector: retire the written index first so a same-index set wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    if (set_ok) begin
      busy_d[set_addr_i] = 1'b1;
    end
  end

  // Busy bit storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Per-port lookup; a forwarded write means the operand is already here.
  always_comb begin
    rbusy_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rbusy_o[i] = en_i && !hit_i[i] &&
                   busy_q[raddr_i[rf_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp
//  Description : Parametrised multi-port register file with write-through
//                bypass, pending-write scoreboard and a start-up sequence
//                that zeroes every entry before accepting traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_RD     = RF_NUM_RD,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_mp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  rf_state_e             state_q;
  rf_state_e             state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  ready;
  logic                  wr_accept;
  logic [NUM_RD-1:0]     hit;

  assign ready     = (state_q == ST_READY);
  assign wr_accept = ready && bus.wen &&
                     !((ZERO_REG != 0) && (bus.waddr == '0));
  assign bus.init_done = ready;

  // State and clear-pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear sequencing: walk every entry once, then serve traffic until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Array write: zero-fill during clear, accepted writes afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_accept) begin
        mem_q[bus.waddr] <= bus.wdata;
      end
    end
  end

  // Read ports: zero register, then forwarded write, then stored value.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_zero;

    assign rd_addr = bus.raddr[rf_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
    assign rd_zero = (ZERO_REG != 0) && (rd_addr == '0);
    assign hit[i]  = (BYPASS != 0) && wr_accept && (rd_addr == bus.waddr);

    assign bus.rdata[rf_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
        (!ready || rd_zero) ? '0          :
        hit[i]              ? bus.wdata   :
                              mem_q[rd_addr];
  end

  reg_file_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RD     (NUM_RD),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .en_i       (ready),
    .clr_i      (wr_accept),
    .clr_addr_i (bus.waddr),
    .set_i      (bus.busy_set),
    .set_addr_i (bus.busy_addr),
    .raddr_i    (bus.raddr),
    .hit_i      (hit),
    .rbusy_o    (bus.rbusy)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_mp
//  Description : Three register-file configurations driven by one shared
//                stimulus stream and checked against a behavioural model:
//                  0: 32x32, 2 ports, bypass, zero register
//                  1: 8x16,  4 ports, bypass, no zero register
//                  2: 32x32, 2 ports, no bypass, zero register
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

  localparam int NI = 3;
  localparam int DWS [NI] = '{32, 16, 32};
  localparam int AWS [NI] = '{5, 3, 5};
  localparam int NRS [NI] = '{2, 4, 2};
  localparam int BYS [NI] = '{1, 1, 0};
  localparam int ZRS [NI] = '{1, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus; each instance takes the low bits it needs.
  logic        s_wen   = 1'b0;
  int          s_waddr = 0;
  logic [31:0] s_wdata = '0;
  int          s_raddr [4] = '{0, 0, 0, 0};
  logic        s_bset  = 1'b0;
  int          s_baddr = 0;

  // Observed outputs, widened to a common shape.
  logic [31:0] o_d    [NI][4];
  logic        o_b    [NI][4];
  logic        o_done [NI];

  // Reference model state.
  logic [31:0] m_mem  [NI][32];
  logic        m_busy [NI][32];
  int          m_cnt  [NI];

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int DW = DWS[k];
    localparam int AW = AWS[k];
    localparam int NR = NRS[k];

    reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus ();

    reg_file_mp #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_RD     (NR),
      .BYPASS     (BYS[k]),
      .ZERO_REG   (ZRS[k])
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    assign bus.wen       = s_wen;
    assign bus.waddr     = AW'(s_waddr);
    assign bus.wdata     = DW'(s_wdata);
    assign bus.busy_set  = s_bset;
    assign bus.busy_addr = AW'(s_baddr);
    assign o_done[k]     = bus.init_done;

    for (genvar i = 0; i < 4; i++) begin : g_p
      if (i < NR) begin : g_on
        assign bus.raddr[i*AW +: AW] = AW'(s_raddr[i]);
        assign o_d[k][i] = 32'(bus.rdata[i*DW +: DW]);
        assign o_b[k][i] = bus.rbusy[i];
      end else begin : g_off
        assign o_d[k][i] = '0;
        assign o_b[k][i] = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dmask(input int k);
    return (DWS[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << DWS[k]) - 32'd1);
  endfunction

  // What port i of instance k must show, given current inputs and model state.
  function automatic void exp_port(input int k, input int i,
                                   output logic [31:0] d, output logic b);
    int dep, ra, wa;
    logic acc;
    dep = 1 << AWS[k];
    ra  = s_raddr[i] & (dep - 1);
    wa  = s_waddr & (dep - 1);
    acc = s_wen && !(ZRS[k] != 0 && wa == 0);
    d = '0;
    b = 1'b0;
    if (m_cnt[k] < dep) return;
    if (ZRS[k] != 0 && ra == 0) begin
      d = '0;
      b = m_busy[k][0];
    end else if (BYS[k] != 0 && acc && ra == wa) begin
      d = s_wdata & dmask(k);
      b = 1'b0;
    end else begin
      d = m_mem[k][ra];
      b = m_busy[k][ra];
    end
  endfunction

  // Model update: reset empties everything, DEPTH idle cycles to come up,
  // then writes store and retire, sets mark (set applied last so it wins).
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      int dep, wa, ba;
      dep = 1 << AWS[k];
      wa  = s_waddr & (dep - 1);
      ba  = s_baddr & (dep - 1);
      if (rst) begin
        m_cnt[k] <= 0;
        for (int j = 0; j < 32; j++) begin
          m_mem[k][j]  <= '0;
          m_busy[k][j] <= 1'b0;
        end
      end else if (m_cnt[k] < dep) begin
        m_cnt[k] <= m_cnt[k] + 1;
      end else begin
        if (s_wen && !(ZRS[k] != 0 && wa == 0)) begin
          m_mem[k][wa]  <= s_wdata & dmask(k);
          m_busy[k][wa] <= 1'b0;
        end
        if (s_bset && !(ZRS[k] != 0 && ba == 0)) begin
          m_busy[k][ba] <= 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        logic [31:0] d;
        logic        b;
        chk($sformatf("init_done k%0d", k), 32'(o_done[k]),
            32'(m_cnt[k] >= (1 << AWS[k])));
        for (int i = 0; i < NRS[k]; i++) begin
          exp_port(k, i, d, b);
          chk($sformatf("rdata k%0d p%0d", k, i), o_d[k][i], d);
          chk($sformatf("rbusy k%0d p%0d", k, i), 32'(o_b[k][i]), 32'(b));
        end
      end
    end
  end

  task automatic set_reads(input int a);
    for (int i = 0; i < 4; i++) s_raddr[i] = a;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick();
    return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7))
                                       : int'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [31:0] md;
    logic        mb;

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset init_done", 32'(o_done[0]), 32'd0);
    chk("reset rdata", o_d[0][1], 32'd0);
    chk("reset rbusy", 32'(o_b[1][3]), 32'd0);

    // Start-up clear with random read addresses.
    nxt();
    rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      nxt();
      for (int i = 0; i < 4; i++) s_raddr[i] = pick();
      @(negedge clk);
      if (e == 7)  chk("clear8 low", 32'(o_done[1]), 32'd0);
      if (e == 8)  chk("clear8 high", 32'(o_done[1]), 32'd1);
      if (e == 31) chk("clear32 low", 32'(o_done[0]), 32'd0);
      if (e == 32) begin
        chk("clear32 high", 32'(o_done[0]), 32'd1);
        chk("clear32 high nobyp", 32'(o_done[2]), 32'd1);
      end
    end

    // Plain write then read on every port.
    nxt(); s_wen = 1'b1; s_waddr = 5; s_wdata = 32'hDEAD_BEEF; set_reads(0);
    nxt(); s_wen = 1'b0; set_reads(5);
    @(negedge clk);
    chk("r5 p0", o_d[0][0], 32'hDEAD_BEEF);
    chk("r5 p1", o_d[0][1], 32'hDEAD_BEEF);
    chk("r5 w16 p3", o_d[1][3], 32'h0000_BEEF);
    exp_port(0, 1, md, mb);
    chk("model r5", md, 32'hDEAD_BEEF);

    // Writes to entry 0.
    nxt(); s_wen = 1'b1; s_waddr = 0; s_wdata = 32'h1234; set_reads(0);
    nxt(); s_wen = 1'b0;
    @(negedge clk);
    chk("r0 zero", o_d[0][0], 32'd0);
    chk("r0 nonzero cfg", o_d[1][2], 32'h1234);
    exp_port(1, 0, md, mb);
    chk("model r0 nonzero", md, 32'h1234);

    // Same-cycle forwarding versus stored value.
    nxt(); s_wen = 1'b1; s_waddr = 7; s_wdata = 32'h1111_1111;
    nxt(); s_wdata = 32'hA5A5_A5A5; set_reads(7);
    @(negedge clk);
    chk("bypass hit", o_d[0][0], 32'hA5A5_A5A5);
    chk("bypass w16 p2", o_d[1][2], 32'h0000_A5A5);
    chk("no bypass old", o_d[2][0], 32'h1111_1111);

    // Scoreboard set / clear / set-wins.
    nxt(); s_wen = 1'b0; s_bset = 1'b1; s_baddr = 9; set_reads(9);
    @(negedge clk);
    chk("busy not yet", 32'(o_b[0][0]), 32'd0);
    nxt(); s_bset = 1'b0;
    @(negedge clk);
    chk("busy set", 32'(o_b[0][0]), 32'd1);
    nxt(); s_wen = 1'b1; s_waddr = 9; s_wdata = 32'h99;
    @(negedge clk);
    chk("busy bypassed", 32'(o_b[0][0]), 32'd0);
    chk("busy fwd data", o_d[0][1], 32'h99);
    chk("busy nobyp", 32'(o_b[2][1]), 32'd1);
    nxt(); s_wen = 1'b0;
    @(negedge clk);
    chk("busy cleared", 32'(o_b[0][0]), 32'd0);
    chk("busy cleared nobyp", 32'(o_b[2][0]), 32'd0);
    nxt(); s_wen = 1'b1; s_wdata = 32'h77; s_bset = 1'b1; s_baddr = 9;
    nxt(); s_wen = 1'b0; s_bset = 1'b0;
    @(negedge clk);
    chk("set wins", 32'(o_b[0][0]), 32'd1);
    chk("set wins nobyp", 32'(o_b[2][1]), 32'd1);
    chk("set wins data", o_d[0][1], 32'h77);
    exp_port(0, 0, md, mb);
    chk("model set wins", 32'(mb), 32'd1);

    // busy_set to entry 0.
    nxt(); s_bset = 1'b1; s_baddr = 0; set_reads(0);
    nxt(); s_bset = 1'b0;
    @(negedge clk);
    chk("r0 never busy", 32'(o_b[0][0]), 32'd0);
    chk("r0 busy nonzero cfg", 32'(o_b[1][0]), 32'd1);

    // Reset mid-clear, with writes and sets hammering throughout.
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0; s_wen = 1'b1; s_waddr = 3; s_wdata = 32'hFFFF_FFFF;
    s_bset = 1'b1; s_baddr = 3; s_raddr[0] = 3; s_raddr[1] = 5;
    repeat (10) nxt();
    rst = 1'b1;
    nxt(); rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      nxt();
      if (e == 32) begin
        s_wen  = 1'b0;
        s_bset = 1'b0;
      end
      @(negedge clk);
      if (e == 31) chk("reclear low", 32'(o_done[0]), 32'd0);
      if (e == 32) begin
        chk("reclear high", 32'(o_done[0]), 32'd1);
        chk("reclear r3", o_d[0][0], 32'd0);
        chk("reclear r5", o_d[0][1], 32'd0);
        chk("reclear busy", 32'(o_b[0][0]), 32'd0);
      end
    end

    // Random traffic with occasional resets.
    repeat (3000) begin
      nxt();
      rst     = ($urandom_range(0, 499) == 0);
      s_wen   = $urandom_range(0, 1) == 1;
      s_waddr = pick();
      s_wdata = $urandom;
      for (int i = 0; i < 4; i++) s_raddr[i] = pick();
      s_bset  = $urandom_range(0, 2) == 0;
      s_baddr = pick();
    end
    nxt();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file with write-through bypass, a pending-write scoreboard and a self-clearing start-up sequence. It replaces the fixed 32x32 two-read-port register file in the CPU datapath. Decode, issue and writeback stages read operands, busy status and newly written data in the same cycle.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH entries
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- ZERO_REG, 1, 1 = entry 0 hardwired to zero, writes and busy-set to it ignored

Ports:
- clk  in  1  sole clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- init_done  out  1  high once start-up clear is complete
- wen  in  1  write enable
- waddr  in  ADDR_WIDTH  write index
- wdata  in  DATA_WIDTH  write data
- raddr  in  NUM_RD*ADDR_WIDTH  packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NUM_RD*DATA_WIDTH  packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
- busy_set  in  1  mark busy_addr as having a pending write
- busy_addr  in  ADDR_WIDTH  index to mark busy
- rbusy  out  NUM_RD  per read port: operand still pending

## Operation
- FSM states: CLEAR, READY. rst forces CLEAR with clear counter = 0.
- CLEAR: each cycle writes 0 to entry[counter] and increments. On counter == DEPTH-1 it moves to READY. wen and busy_set are ignored. rdata = 0 and rbusy = 0 on all ports.
- READY: stays until rst.
- Write in READY: if wen and not (ZERO_REG and waddr == 0), entry[waddr] <= wdata on the posedge.
- Read: combinational. rdata_i = 0 if ZERO_REG and raddr_i == 0.
  - Else, if BYPASS and wen and raddr_i == waddr (write not suppressed), rdata_i = wdata.
  - Else rdata_i = entry[raddr_i].
- Scoreboard: DEPTH busy bits.
  - busy_set sets busy[busy_addr]. Ignored for index 0 when ZERO_REG.
  - An accepted write clears busy[waddr].
  - If busy_set and a write hit the same index in the same cycle, set wins: a new producer is issued.
- rbusy_i = busy[raddr_i], forced to 0 when a bypass hit occurs on port i. With BYPASS = 0, rbusy_i = busy[raddr_i] regardless of the concurrent write.
- Multiple read ports reading the same index always receive identical data and status.

## Timing
- Reset values: init_done = 0, all busy = 0, rdata = 0, rbusy = 0.
- Start-up clear takes exactly DEPTH cycles after rst deasserts. init_done rises on the edge that completes the write of entry DEPTH-1 and stays high.
- rst asserted mid-clear restarts the clear from entry 0.
- rst asserted in READY re-clears all entries and drops init_done the next cycle.
- Read latency 0 (combinational). Write visible through the array from the cycle after the write edge. Visible in the same cycle only via bypass.
- Busy-bit updates take effect on the edge and appear on rbusy the following cycle.
- No throughput limit: one write and one busy_set every cycle in READY.

## Structure
- Shared package `reg_file_pkg`: FSM state typedef (CLEAR, READY), default width constants, and a pack/unpack index helper for the flattened port buses.
- One natural sub-module: `reg_file_scoreboard`, which holds the busy-bit vector, the set/clear priority and the per-port rbusy lookup.
- Storage array, clear FSM and read muxing stay in the top module, with the read mux in a generate loop over NUM_RD.

## Test plan
- Reset then idle: init_done low for 32 cycles, high on the 33rd. Reading any index gives 0. rbusy all 0.
- Write 0xDEADBEEF to r5, then read r5 on both ports next cycle: 0xDEADBEEF on both. Write 0x1234 to r0: reads of r0 stay 0.
- Bypass: in one cycle wen = 1, waddr = 7, wdata = 0xA5A5A5A5, raddr0 = 7. rdata0 = 0xA5A5A5A5 in that cycle. With BYPASS = 0 the same cycle returns the old value.
- Scoreboard:
  - busy_set r9: rbusy for r9 is 1 next cycle.
  - Write r9: clears it, and rbusy is 0 in the write cycle via bypass.
  - busy_set and write r9 in the same cycle: r9 stays busy.
- Reset mid-clear: assert rst at clear cycle 10 for one cycle. init_done rises exactly 32 cycles after release. Writes attempted during clear are not visible afterwards.
- Parameter sweep with NUM_RD = 4, ADDR_WIDTH = 3, DATA_WIDTH = 16: clear takes 8 cycles, and random write/read traffic matches the reference model on all four ports.
